// File: rtl/ddr3_responder.sv
// rtl/ddr3_responder.sv - DDR3 memory-model responder with bank tracking, latency FSM and protocol error reporting
// Optional build macro: DDR3_RESP_TIMING_CHECK_EN enables per-bank ACT-to-READ/WRITE (tRCD) checking.
module ddr3_responder #(
  parameter int RL   = 16,
  parameter int WL   = 16,
  parameter int TRCD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_bar,
  input  logic        ras_bar,
  input  logic        cas_bar,
  input  logic        we_bar,
  input  logic [2:0]  BA,
  input  logic [12:0] A,
  input  logic [1:0]  DM,
  input  logic [15:0] DQ_in,
  output logic [15:0] DQ_out,
  output logic [1:0]  DQS_out,
  output logic        ts_con,
  output logic        proto_err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_CAP} state_t;

  // Counter preloads: read counts down to 0, write counts down to 1 so the
  // capture state occupies the cycle before the WL-th edge.
  localparam logic [15:0] RL_LOAD = (RL > 0) ? 16'(RL - 1) : 16'd0;
  localparam logic [15:0] WL_LOAD = (WL > 0) ? 16'(WL - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] lat_q, lat_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  open_q;
  logic [12:0] row_q [8];
  logic [15:0] mem [1024];

  logic [3:0]  cmd;
  logic        is_act, is_rd, is_wr, is_pre;
  logic        act_ok, wr_en, trcd_ok, err_d;
  logic [1:0]  code_d;
  logic [9:0]  cmd_idx;

  assign cmd     = {cs_bar, ras_bar, cas_bar, we_bar};
  assign is_act  = (cmd == 4'b0011);
  assign is_rd   = (cmd == 4'b0101);
  assign is_wr   = (cmd == 4'b0100);
  assign is_pre  = (cmd == 4'b0010);
  assign cmd_idx = {BA, row_q[BA][3:0], A[2:0]};

`ifdef DDR3_RESP_TIMING_CHECK_EN
  localparam logic [15:0] TRCD_LOAD = (TRCD > 0) ? 16'(TRCD - 1) : 16'd0;
  logic [15:0] trcd_q [8];

  assign trcd_ok = (trcd_q[BA] == 16'd0);

  // Per-bank tRCD down-counters, reloaded on every accepted ACT
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset)
        trcd_q[i] <= '0;
      else if (act_ok && (BA == 3'(i)))
        trcd_q[i] <= TRCD_LOAD;
      else if (trcd_q[i] != 16'd0)
        trcd_q[i] <= trcd_q[i] - 16'd1;
    end
  end
`else
  assign trcd_ok = 1'b1;
`endif

  // Next-state, latency countdown, command acceptance and error classification
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    code_d  = 2'b00;
    act_ok  = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      RD_WAIT:  if (lat_q == 16'd0) state_d = RD_DRIVE; else lat_d = lat_q - 16'd1;
      RD_DRIVE: state_d = IDLE;
      WR_WAIT:  if (lat_q <= 16'd1) state_d = WR_CAP; else lat_d = lat_q - 16'd1;
      WR_CAP:   begin state_d = IDLE; wr_en = 1'b1; end
      default:  ;
    endcase

    if (is_rd || is_wr) begin
      if (!open_q[BA]) begin
        err_d = 1'b1; code_d = 2'b01;
      end else if (state_q != IDLE) begin
        err_d = 1'b1; code_d = 2'b10;
      end else if (!trcd_ok) begin
        err_d = 1'b1; code_d = 2'b11;
      end else begin
        idx_d = cmd_idx;
        if (is_rd) begin
          state_d = RD_WAIT;
          lat_d   = RL_LOAD;
        end else begin
          state_d = (WL <= 1) ? WR_CAP : WR_WAIT;
          lat_d   = WL_LOAD;
        end
      end
    end

    if (is_act) begin
      if (open_q[BA]) begin
        err_d = 1'b1; code_d = 2'b11;
      end else begin
        act_ok = 1'b1;
      end
    end
  end

  // State, bank bookkeeping and registered read-data / error outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      idx_q     <= '0;
      open_q    <= '0;
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
      DQ_out    <= '0;
      DQS_out   <= 2'b00;
      ts_con    <= 1'b0;
      proto_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      if (act_ok) begin
        open_q[BA] <= 1'b1;
        row_q[BA]  <= A;
      end
      if (is_pre) begin
        if (A[10]) open_q <= '0;
        else       open_q[BA] <= 1'b0;
      end
      DQ_out    <= (state_d == RD_DRIVE) ? mem[idx_q] : 16'h0000;
      DQS_out   <= (state_d == RD_DRIVE) ? 2'b11 : 2'b00;
      ts_con    <= (state_d == RD_DRIVE);
      proto_err <= err_d;
      err_code  <= code_d;
    end
  end

  // Byte-masked write capture; storage survives reset, a reset edge cancels the capture
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      if (!DM[1]) mem[idx_q][15:8] <= DQ_in[15:8];
      if (!DM[0]) mem[idx_q][7:0]  <= DQ_in[7:0];
    end
  end

endmodule

// File: tb/tb_ddr3_responder.sv
// tb/tb_ddr3_responder.sv - directed and randomized check of ddr3_responder against a cycle-stamped reference model
module tb_ddr3_responder;

  localparam int RL   = 16;
  localparam int WL   = 16;
  localparam int TRCD = 16;
`ifdef DDR3_RESP_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_bar, ras_bar, cas_bar, we_bar;
  logic [2:0]  BA;
  logic [12:0] A;
  logic [1:0]  DM;
  logic [15:0] DQ_in;
  logic [15:0] DQ_out;
  logic [1:0]  DQS_out;
  logic        ts_con, proto_err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  ddr3_responder #(.RL(RL), .WL(WL), .TRCD(TRCD)) dut (
    .clk(clk), .reset(reset),
    .cs_bar(cs_bar), .ras_bar(ras_bar), .cas_bar(cas_bar), .we_bar(we_bar),
    .BA(BA), .A(A), .DM(DM), .DQ_in(DQ_in),
    .DQ_out(DQ_out), .DQS_out(DQS_out), .ts_con(ts_con),
    .proto_err(proto_err), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bank table, byte-known memory image and event timestamps
  longint     cyc = 0;
  bit         open_m [8];
  logic [12:0] row_m [8];
  longint     act_t [8];
  logic [15:0] mem_m [1024];
  bit   [1:0] known [1024];
  longint     busy_until = -1;
  longint     rd_at = -1;
  longint     wr_at = -1;
  int         rd_idx, wr_idx;

  int          drives = 0;
  logic [15:0] last_dq = 16'h0;
  logic [1:0]  last_code = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_cycle(input bit rst, input logic [3:0] c, input logic [2:0] ba,
                          input logic [12:0] a, input logic [15:0] dq, input logic [1:0] dm);
    bit          exp_ts;
    logic [15:0] exp_dq, mask;
    logic [1:0]  code;
    reset = rst;
    {cs_bar, ras_bar, cas_bar, we_bar} = c;
    BA = ba; A = a; DQ_in = dq; DM = dm;
    @(posedge clk);
    cyc++;
    exp_ts = 1'b0; exp_dq = 16'h0; mask = 16'hFFFF; code = 2'b00;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin open_m[i] = 1'b0; row_m[i] = '0; end
      busy_until = -1; rd_at = -1; wr_at = -1;
    end else begin
      if (wr_at == cyc) begin
        if (!dm[1]) begin mem_m[wr_idx][15:8] = dq[15:8]; known[wr_idx][1] = 1'b1; end
        if (!dm[0]) begin mem_m[wr_idx][7:0]  = dq[7:0];  known[wr_idx][0] = 1'b1; end
        wr_at = -1;
      end
      if (rd_at == cyc) begin
        exp_ts = 1'b1;
        exp_dq = mem_m[rd_idx];
        mask   = {{8{known[rd_idx][1]}}, {8{known[rd_idx][0]}}};
        rd_at  = -1;
      end
      if (c == C_RD || c == C_WR) begin
        if (!open_m[ba])                          code = 2'b01;
        else if (cyc <= busy_until)               code = 2'b10;
        else if (TCHK && (cyc - act_t[ba] < TRCD)) code = 2'b11;
        else if (c == C_RD) begin
          rd_idx = {ba, row_m[ba][3:0], a[2:0]};
          rd_at = cyc + RL; busy_until = cyc + RL + 1;
        end else begin
          wr_idx = {ba, row_m[ba][3:0], a[2:0]};
          wr_at = cyc + WL; busy_until = cyc + WL;
        end
      end else if (c == C_ACT) begin
        if (open_m[ba]) code = 2'b11;
        else begin open_m[ba] = 1'b1; row_m[ba] = a; act_t[ba] = cyc; end
      end else if (c == C_PRE) begin
        if (a[10]) for (int i = 0; i < 8; i++) open_m[i] = 1'b0;
        else open_m[ba] = 1'b0;
      end
    end
    #1;
    check("ts_con", ts_con, exp_ts);
    check("dqs", DQS_out, exp_ts ? 2'b11 : 2'b00);
    check("dq", DQ_out & mask, exp_dq & mask);
    check("proto_err", proto_err, code != 2'b00);
    check("err_code", err_code, code);
    if (ts_con) begin drives++; last_dq = DQ_out; end
    if (proto_err) last_code = err_code;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++)
      do_cycle(1'b0, C_NOP, 3'($urandom), 13'($urandom), 16'($urandom), 2'($urandom));
  endtask

  task automatic cmd(input logic [3:0] c, input logic [2:0] ba, input logic [12:0] a);
    do_cycle(1'b0, c, ba, a, 16'($urandom), 2'($urandom));
  endtask

  int d0;

  initial begin
    for (int i = 0; i < 1024; i++) begin known[i] = 2'b00; mem_m[i] = '0; end
    for (int i = 0; i < 8; i++) act_t[i] = 0;
    do_cycle(1'b1, C_NOP, 3'd0, 13'd0, 16'd0, 2'd0);
    do_cycle(1'b1, C_NOP, 3'd0, 13'd0, 16'd0, 2'd0);

    // Basic write then read-back
    cmd(C_ACT, 3'd2, 13'h0005);
    nop(15);
    cmd(C_WR, 3'd2, 13'h0003);
    nop(15);
    do_cycle(1'b0, C_NOP, 3'd0, 13'd0, 16'hBEEF, 2'b00);
    d0 = drives;
    cmd(C_RD, 3'd2, 13'h0003);
    nop(20);
    check("req023_drives", drives - d0, 1);
    check("req023_data", last_dq, 16'hBEEF);

    // Upper byte masked overwrite
    cmd(C_WR, 3'd2, 13'h0003);
    nop(15);
    do_cycle(1'b0, C_NOP, 3'd0, 13'd0, 16'h1234, 2'b10);
    cmd(C_RD, 3'd2, 13'h0003);
    nop(20);
    check("req024_data", last_dq, 16'hBE34);

    // Read to a closed bank
    d0 = drives;
    cmd(C_RD, 3'd5, 13'h0001);
    nop(20);
    check("req025_code", last_code, 2'b01);
    check("req025_drives", drives - d0, 0);

    // Second read while busy
    d0 = drives;
    cmd(C_RD, 3'd2, 13'h0003);
    nop(2);
    cmd(C_RD, 3'd2, 13'h0003);
    nop(20);
    check("req026_code", last_code, 2'b10);
    check("req026_drives", drives - d0, 1);

    // Read shortly after ACT
    d0 = drives;
    last_code = 2'b00;
    cmd(C_ACT, 3'd3, 13'h0002);
    nop(4);
    cmd(C_RD, 3'd3, 13'h0000);
    nop(20);
`ifdef DDR3_RESP_TIMING_CHECK_EN
    check("req027_code", last_code, 2'b11);
    check("req027_drives", drives - d0, 0);
`else
    check("req027_code", last_code, 2'b00);
    check("req027_drives", drives - d0, 1);
`endif

    // Reset mid-write cancels capture
    cmd(C_WR, 3'd2, 13'h0003);
    for (int i = 0; i < 7; i++) do_cycle(1'b0, C_NOP, 3'd0, 13'd0, 16'hAAAA, 2'b00);
    do_cycle(1'b1, C_NOP, 3'd0, 13'd0, 16'hAAAA, 2'b00);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, C_NOP, 3'd0, 13'd0, 16'hAAAA, 2'b00);
    cmd(C_ACT, 3'd2, 13'h0005);
    nop(16);
    d0 = drives;
    cmd(C_RD, 3'd2, 13'h0003);
    nop(20);
    check("req028_drives", drives - d0, 1);
    check("req028_data", last_dq, 16'hBE34);

    // Randomized traffic on a few banks, occasional reset
    for (int n = 0; n < 4000; n++) begin
      int          r;
      logic [3:0]  c;
      logic [12:0] a;
      r = $urandom_range(0, 99);
      a = 13'($urandom);
      if ($urandom_range(0, 3) != 0) a[10] = 1'b0;
      if (r < 8)       c = C_ACT;
      else if (r < 12) c = C_PRE;
      else if (r < 22) c = C_RD;
      else if (r < 30) c = C_WR;
      else if (r < 34) c = 4'($urandom);
      else             c = C_NOP;
      do_cycle($urandom_range(0, 499) == 0, c, 3'($urandom_range(0, 3)), a,
               16'($urandom), 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_responder.md
DDR3_RESPONDER -- requirements
Module: ddr3_responder

Interface
REQ-001 The block SHALL have parameter RL, default 16, meaning read latency in clk cycles from READ command to read data.
REQ-002 The block SHALL have parameter WL, default 16, meaning write latency in clk cycles from WRITE command to write-data capture.
REQ-003 The block SHALL have parameter TRCD, default 16, meaning the minimum clk cycles from ACT to READ/WRITE on the same bank.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning; clock and reset come first.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- cs_bar, ras_bar, cas_bar, we_bar  input  1 each  command pins.
- BA  input  3  bank address.
- A  input  13  row/column address.
- DM  input  2  write byte mask; 1 = byte masked.
- DQ_in  input  16  write data from controller.
- DQ_out  output  16  read data.
- DQS_out  output  2  read strobe.
- ts_con  output  1  read-data drive enable.
- proto_err  output  1  one-cycle protocol error pulse.
- err_code  output  2  error cause, valid when proto_err=1.

Function
REQ-005 Commands SHALL be sampled on each rising clk edge; {cs_bar,ras_bar,cas_bar,we_bar} decodes as follows: 0011=ACT, 0101=READ, 0100=WRITE, 0010=PRE. Every other value, and any value with cs_bar=1, SHALL be treated as NOP.
REQ-006 Per-bank state SHALL be 8 open flags plus 8 row registers holding A[12:0] captured at ACT.
REQ-007 PRE SHALL close bank BA; when A[10]=1, PRE SHALL close all banks.
REQ-008 Storage SHALL be 1024 x 16 bits, indexed {BA, row[3:0], A[2:0]}, where row is the stored row of bank BA.
REQ-009 The data FSM SHALL have states IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_CAP.
- READ accepted in IDLE: go to RD_WAIT and latch the index.
- WRITE accepted in IDLE: go to WR_WAIT and latch the index.
REQ-010 RD_DRIVE SHALL last exactly one cycle, starting RL cycles after the READ sample edge. During it: DQ_out = mem[index], ts_con = 1, DQS_out = 2'b11. The FSM then returns to IDLE.
REQ-011 WR_CAP SHALL occur on the edge exactly WL cycles after the WRITE sample edge. It writes DQ_in[15:8] unless DM[1]=1 and DQ_in[7:0] unless DM[0]=1, then returns to IDLE.
REQ-012 Outside RD_DRIVE, the outputs SHALL be DQ_out = 0, ts_con = 0, DQS_out = 2'b00.
REQ-013 A READ or WRITE to a closed bank SHALL be ignored and SHALL raise proto_err with err_code = 2'b01.
REQ-014 A READ or WRITE while the FSM is not IDLE SHALL be ignored and SHALL raise proto_err with err_code = 2'b10.
REQ-015 ACT to an already-open bank SHALL be ignored and SHALL raise proto_err with err_code = 2'b11.
REQ-016 ACT and PRE SHALL be processed in every FSM state. A PRE during RD_WAIT or WR_WAIT SHALL NOT cancel the pending access, because the index is already latched.
REQ-017 When a new command and WR_CAP or RD_DRIVE fall on the same edge, both SHALL take effect. A READ sampled on a WR_CAP edge SHALL be rejected per REQ-014.
REQ-018 When several errors apply to one command, the priority SHALL be 01, then 10, then 11/timing.

Reset
REQ-019 Reset SHALL have these effects on the next edge:
- FSM to IDLE.
- All banks closed, row registers 0, latency and tRCD counters 0.
- DQ_out = 0, DQS_out = 2'b00, ts_con = 0, proto_err = 0, err_code = 0.
REQ-020 Reset mid-operation SHALL cancel any pending read or write with no memory update and no drive cycle.
REQ-021 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-022 Macro DDR3_RESP_TIMING_CHECK_EN SHALL select tRCD checking.
- Defined: each bank has a counter loaded at ACT. A READ or WRITE issued fewer than TRCD cycles after its bank's ACT SHALL be ignored, with proto_err = 1 and err_code = 2'b11.
- Undefined: no tRCD counters exist, and READ/WRITE to an open bank are accepted immediately.

Verification
REQ-023 ACT BA=2 A=0x0005, wait 16 cycles, WRITE BA=2 A=0x003, then DQ_in = 0xBEEF, DM = 00 exactly 16 cycles later. Then READ BA=2 A=0x003 -> 16 cycles later one cycle with ts_con=1, DQ_out=0xBEEF, DQS_out=11.
REQ-024 Overwrite the same location with DQ_in = 0x1234, DM = 2'b10, then READ -> DQ_out = 0xBE34.
REQ-025 READ BA=5 with no prior ACT -> proto_err pulse, err_code = 01, and no ts_con pulse within 20 cycles.
REQ-026 Second READ 3 cycles after the first accepted READ -> err_code = 10, exactly one drive cycle.
REQ-027 With DDR3_RESP_TIMING_CHECK_EN: READ 5 cycles after ACT -> err_code = 11. Without it: the same READ is accepted and data returns after RL.
REQ-028 Assert reset 8 cycles after WRITE with DQ_in = 0xAAAA -> no capture; a later READ of that location returns the prior contents.
